// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, signed/unsigned, abortable.
// Optional DIV_ZERO_DETECT_EN: short-circuits divide-by-zero through BYZERO and raises dz_o.
module div_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               dz_o
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]   rem, rem_nxt;
    logic [WIDTH-1:0]   dvd, dvd_nxt;
    logic [WIDTH-1:0]   dsr, dsr_nxt;
    logic               neg_q, neg_q_nxt;
    logic               neg_r, neg_r_nxt;
    logic [2*WIDTH-1:0] result_nxt;
    logic               ready_nxt;
    logic               busy_nxt;
`ifdef DIV_ZERO_DETECT_EN
    logic               dz_nxt;
`endif

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   dvd_step;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? WIDTH'(-v) : v;
    endfunction

    // One restoring step; a set top bit of the shifted remainder always exceeds the divisor
    always_comb begin
        shifted  = {rem, dvd[WIDTH-1]};
        diff     = shifted - {1'b0, dsr};
        ge       = shifted[WIDTH] | ~diff[WIDTH];
        rem_step = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvd_step = {dvd[WIDTH-2:0], ge};
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rem_nxt    = rem;
        dvd_nxt    = dvd;
        dsr_nxt    = dsr;
        neg_q_nxt  = neg_q;
        neg_r_nxt  = neg_r;
        result_nxt = result_o;
        ready_nxt  = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
        dz_nxt     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start_i && !annul_i) begin
                    dvd_nxt   = magnitude(opdata1_i, signed_i);
                    dsr_nxt   = magnitude(opdata2_i, signed_i);
                    rem_nxt   = '0;
                    cnt_nxt   = '0;
                    neg_q_nxt = signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_r_nxt = signed_i & opdata1_i[WIDTH-1];
`ifdef DIV_ZERO_DETECT_EN
                    state_nxt = (opdata2_i == '0) ? BYZERO : ON;
`else
                    state_nxt = ON;
`endif
                end
            end
            BYZERO: begin
`ifdef DIV_ZERO_DETECT_EN
                if (annul_i) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt  = END;
                    ready_nxt  = 1'b1;
                    dz_nxt     = 1'b1;
                    result_nxt = '0;
                end
`else
                state_nxt = IDLE;
`endif
            end
            ON: begin
                if (annul_i) begin
                    state_nxt = IDLE;
                end else begin
                    rem_nxt = rem_step;
                    dvd_nxt = dvd_step;
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        state_nxt  = END;
                        ready_nxt  = 1'b1;
                        result_nxt = {neg_r ? WIDTH'(-rem_step) : rem_step,
                                      neg_q ? WIDTH'(-dvd_step) : dvd_step};
                    end
                end
            end
            END:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dsr      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rem      <= rem_nxt;
            dvd      <= dvd_nxt;
            dsr      <= dsr_nxt;
            neg_q    <= neg_q_nxt;
            neg_r    <= neg_r_nxt;
            result_o <= result_nxt;
            ready_o  <= ready_nxt;
            busy_o   <= busy_nxt;
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dz_o <= 1'b0;
        end else begin
            dz_o <= dz_nxt;
        end
    end
`else
    assign dz_o = 1'b0;
`endif

endmodule

// File: tb/tb_div_iter.sv
// Randomized and directed bench for div_iter (WIDTH=32 and WIDTH=8 instances) against an arithmetic model.
module tb_div_iter;
    localparam int unsigned W  = 32;
    localparam int unsigned W8 = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            signed_i, start, annul;
    logic [W-1:0]    op1, op2;
    logic [2*W-1:0]  result;
    logic            ready, busy, dz_o;

    logic            signed8, start8, annul8;
    logic [W8-1:0]   op1_8, op2_8;
    logic [2*W8-1:0] result8;
    logic            ready8, busy8, dz8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .signed_i(signed_i), .opdata1_i(op1), .opdata2_i(op2),
        .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready),
        .busy_o(busy), .dz_o(dz_o)
    );

    div_iter #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst), .signed_i(signed8), .opdata1_i(op1_8), .opdata2_i(op2_8),
        .start_i(start8), .annul_i(annul8), .result_o(result8), .ready_o(ready8),
        .busy_o(busy8), .dz_o(dz8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division, remainder follows the dividend's sign
    function automatic logic [63:0] model32(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [15:0] model8(input logic s, input logic [7:0] a, input logic [7:0] b);
        longint sa, sb, q, r;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({56'd0, a});
            sb = longint'({56'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[7:0], q[7:0]};
    endfunction

    // Called at a negedge; start is sampled at the next posedge (cycle t), lat counts cycles to ready.
    task automatic div32(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input bit junk,
                         output int lat, output logic [2*W-1:0] res, output logic dz);
        int n;
        int busy_lo;
        signed_i = s; op1 = a; op2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; n = 1; busy_lo = 0;
        op1 = $urandom; op2 = $urandom;
        while (!ready && n < 100) begin
            if (!busy) busy_lo++;
            start = (junk && n == 3);
            if (junk && n == 3) signed_i = ~s;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        lat = ready ? n : -1;
        res = result;
        dz  = dz_o;
        if (!busy) busy_lo++;
        check("busy_during_op", 64'(busy_lo), 64'd0);
        @(negedge clk);
        check("ready_one_cycle", {63'd0, ready}, 64'd0);
        check("busy_back_idle", {63'd0, busy}, 64'd0);
    endtask

    task automatic div8(input logic s, input logic [W8-1:0] a, input logic [W8-1:0] b,
                        input logic [2*W8-1:0] exp);
        int n;
        signed8 = s; op1_8 = a; op2_8 = b; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; n = 1;
        while (!ready8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("w8_latency", 64'(ready8 ? n : -1), 64'd9);
        check("w8_result", 64'(result8), 64'(exp));
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int n;
        int seen;
        logic [2*W-1:0] res;
        logic [2*W-1:0] prev;
        logic dz;
        logic s;
        logic [W-1:0] a, b;
        logic [W8-1:0] a8, b8;

        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_i = 1'b0; op1 = '0; op2 = '0;
        start8 = 1'b0; annul8 = 1'b0; signed8 = 1'b0; op1_8 = '0; op2_8 = '0;
        repeat (2) @(negedge clk);
        check("rst_result", result, 64'd0);
        check("rst_ready_busy_dz", {61'd0, ready, busy, dz_o}, 64'd0);
        check("rst_w8_outputs", {45'd0, result8, ready8, busy8, dz8}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        div32(1'b0, 32'd100, 32'd7, 1'b0, lat, res, dz);
        check("lat_100_7", 64'(lat), 64'd33);
        check("res_100_7", res, {32'd2, 32'd14});
        check("dz_100_7", {63'd0, dz}, 64'd0);

        div32(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, res, dz);
        check("lat_m7_2", 64'(lat), 64'd33);
        check("res_m7_2", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        div32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, res, dz);
        check("res_mostneg_m1", res, {32'd0, 32'h8000_0000});
        check("dz_mostneg_m1", {63'd0, dz}, 64'd0);

        div32(1'b0, 32'd5, 32'd0, 1'b0, lat, res, dz);
`ifdef DIV_ZERO_DETECT_EN
        check("lat_div0", 64'(lat), 64'd2);
        check("res_div0", res, 64'd0);
        check("dz_div0", {63'd0, dz}, 64'd1);
`else
        check("lat_div0", 64'(lat), 64'd33);
        check("res_div0", res, {32'd5, 32'hFFFF_FFFF});
        check("dz_div0", {63'd0, dz}, 64'd0);
`endif

        // start with annul in IDLE is dropped
        div32(1'b0, 32'd9, 32'd4, 1'b0, lat, prev, dz);
        check("res_9_4", prev, {32'd1, 32'd2});
        signed_i = 1'b0; op1 = 32'd50; op2 = 32'd5; start = 1'b1; annul = 1'b1;
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        check("start_annul_idle", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check("start_annul_noready", {63'd0, ready}, 64'd0);

        // annul at t+10, restart at t+11
        op1 = 32'd1234; op2 = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0; n = 1; seen = 0;
        while (n < 10) begin
            if (ready) seen++;
            @(negedge clk);
            n++;
        end
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        if (ready) seen++;
        check("annul_idle", {63'd0, busy}, 64'd0);
        check("annul_no_ready", 64'(seen), 64'd0);
        check("annul_result_held", result, prev);
        div32(1'b0, 32'd77, 32'd3, 1'b0, lat, res, dz);
        check("lat_after_annul", 64'(lat), 64'd33);
        check("res_after_annul", res, {32'd2, 32'd25});

        // stray start while busy must not disturb latched operands
        div32(1'b0, 32'd1000, 32'd9, 1'b1, lat, res, dz);
        check("junk_start_lat", 64'(lat), 64'd33);
        check("junk_start_res", res, {32'd1, 32'd111});

        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            a = (i % 7 == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(1, 15));
                1:       b = 32'($urandom);
                2:       b = 32'hFFFF_FFFF;
                default: b = 32'($urandom) >> $urandom_range(0, 31);
            endcase
            if (b == '0) b = 32'd1;
            div32(s, a, b, 1'b0, lat, res, dz);
            check("rand_lat", 64'(lat), 64'd33);
            check("rand_res", res, model32(s, a, b));
        end

        // reset mid-operation with stray starts
        op1 = 32'd500; op2 = 32'd7; signed_i = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; n = 1;
        while (n < 5) begin
            start = (n == 2 || n == 3);
            op1 = $urandom;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_result", result, 64'd0);
        check("midrst_flags", {61'd0, ready, busy, dz_o}, 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready || busy) seen++;
        end
        check("midrst_quiet", 64'(seen), 64'd0);

        div8(1'b0, 8'd255, 8'd16, {8'd15, 8'd15});
        for (int i = 0; i < 8; i++) begin
            s  = 1'($urandom_range(0, 1));
            a8 = 8'($urandom);
            b8 = 8'($urandom_range(1, 255));
            div8(s, a8, b8, model8(s, a8, b8));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
